rle_decoder: RTL and testbench
==============================

RLE_DECODER -- requirements
Module: rle_decoder

Interface
REQ-001 Parameter: ADDR_BITS, 16, width of flash byte address.
REQ-002 Parameter: FIFO_DEPTH, 2, run-buffer entries, power of two, at least 2.
REQ-003 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: frame_addr  in  ADDR_BITS  flash byte address of the first RLE word, sampled on frame_start.
REQ-006 Port: frame_start  in  1  one-cycle pulse that restarts decoding from frame_addr.
REQ-007 Port: next_pixel  in  1  pixel consumer advances one pixel this cycle.
REQ-008 Port: colour  out  6  current pixel, RGB222.
REQ-009 Port: colour_valid  out  1  colour holds a decoded run.
REQ-010 Port: underrun  out  1  sticky, cleared by frame_start or rst.
REQ-011 Port: flash_addr  out  ADDR_BITS  read start address to the flash controller.
REQ-012 Port: flash_start  out  1  start_read pulse.
REQ-013 Port: flash_stop  out  1  stop_read level.
REQ-014 Port: flash_continue  out  1  continue_read pulse.
REQ-015 Port: flash_data  in  16  returned word, big-endian; [15:6] run length, [5:0] colour.
REQ-016 Port: flash_busy  in  1  controller busy.

Function
REQ-017 Fetch FSM states: STOP, START, WAIT, HOLD, DONE.
REQ-018 STOP: flash_stop=1. On frame_start go to START next cycle. Flush FIFO.
REQ-019 START: one-cycle flash_start=1 with flash_addr=frame_addr, flash_stop=0, then WAIT.
REQ-020 WAIT: ignore flash_busy on its first cycle. Capture flash_data on the first later cycle flash_busy=0, then HOLD.
REQ-021 Captured run length 0 = end marker: not pushed, go to DONE. Otherwise push {length, colour} into FIFO.
REQ-022 HOLD: when FIFO not full (pop-this-cycle counts as not full), pulse flash_continue for one cycle and go to WAIT.
REQ-023 DONE: flash_stop=1. Hold until frame_start.
REQ-024 Output stage: run counter (10 bits) and colour register.
  - Idle with FIFO non-empty: load the head entry within 1 cycle and assert colour_valid.
  - next_pixel with counter>1: decrement.
  - next_pixel with counter==1: pop the next entry in the same cycle if available; colour changes on the following cycle.
REQ-025 next_pixel at run end with FIFO empty: colour_valid=0, colour=0.
  - Set underrun if the FSM is not in DONE. An empty FIFO after DONE is end of frame, not underrun.
REQ-026 next_pixel while colour_valid=0: ignored, counter unchanged.
REQ-027 FIFO push and pop in the same cycle are both honoured, including when full.
REQ-028 frame_start has priority over every other event. In the same cycle it:
  - flushes the FIFO;
  - clears the counter, colour_valid and underrun;
  - abandons any in-flight read by driving flash_stop=1 for one cycle before START.
REQ-029 Latency: frame_start to first colour_valid is at most controller read time + 4 cycles.

Reset
REQ-030 rst forces state STOP, FIFO empty, counter 0, colour=0, colour_valid=0, underrun=0.
REQ-031 rst forces flash_start=0, flash_continue=0, flash_stop=1, flash_addr=0.
REQ-032 rst asserted mid-read returns everything to the reset values on the next edge; no partial word is pushed.

Structure
REQ-033 Package rle_pkg shall hold:
  - run field widths (RUN_BITS=10, COLOUR_BITS=6);
  - END_MARKER=0;
  - fetch-state enum.
REQ-034 FIFO shall be sub-module rle_run_fifo (synchronous, full/empty flags, same-cycle push/pop).

Verification
REQ-035 Words 0x0081, 0x00C2, 0x0000 (runs 2×colour 1, 3×colour 2, end) with next_pixel held high:
  - colour sequence 1,1,2,2,2 then colour_valid=0;
  - underrun=0;
  - flash_stop=1 after the end word.
REQ-036 Flash model with busy length 20 cycles and runs of length 1 under continuous next_pixel:
  - underrun=1 on the first starved pixel;
  - colour=0 while starved.
REQ-037 next_pixel low for 50 cycles with FIFO full:
  - no flash_continue issued;
  - after the first pop, exactly one flash_continue within 2 cycles.
REQ-038 frame_start while WAIT with flash_busy=1:
  - flash_stop pulses;
  - START issues frame_addr=0x1234;
  - the old word is never displayed.
REQ-039 rst asserted for 1 cycle mid-run: all outputs at reset values next cycle; the decoder stays in STOP until frame_start.

Source files
------------

// File: rtl/rle_pkg.sv
// rle_pkg -- shared definitions for the RLE frame decoder.
// Holds the run-word field widths, the end-of-frame marker, the fetch FSM
// state encoding and the run-buffer entry layout used by rle_decoder and
// rle_run_fifo.
package rle_pkg;

    localparam int RUN_BITS    = 10;
    localparam int COLOUR_BITS = 6;
    localparam int ENTRY_BITS  = RUN_BITS + COLOUR_BITS;

    // A run length of zero terminates the frame.
    localparam logic [RUN_BITS-1:0] END_MARKER = 10'd0;

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_e;

    // Flash word layout: [15:6] run length, [5:0] RGB222 colour.
    typedef struct packed {
        logic [RUN_BITS-1:0]    len;
        logic [COLOUR_BITS-1:0] colour;
    } run_entry_t;

    function automatic run_entry_t to_entry(input logic [ENTRY_BITS-1:0] word);
        to_entry = word;
    endfunction

endpackage

// File: rtl/rle_run_fifo.sv
// rle_run_fifo -- small synchronous run buffer with show-ahead read.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           empties the buffer on the next edge
//   push, push_data write one entry (accepted when not full or popping)
//   pop, pop_data   pop_data always shows the head entry; pop removes it
//   full, empty     occupancy flags
// Push and pop in the same cycle are both honoured, including when full.
module rle_run_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_FULL);
    assign do_pop_s  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push_s = push && (!full || do_pop_s);
    assign pop_data  = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the buffer is empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/rle_decoder.sv
// rle_decoder -- streams RLE-encoded pixels from flash to a pixel consumer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_addr, frame_start  start address and restart pulse for a frame
//   next_pixel               consumer advances one pixel
//   colour, colour_valid     current pixel (RGB222) and its qualifier
//   underrun                 sticky: a run ended with nothing buffered mid-frame
//   flash_addr/start/stop/continue  read commands to the flash controller
//   flash_data, flash_busy   returned word and controller busy
// A fetch FSM keeps the run buffer topped up; an output stage counts pixels
// down through the head run.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int ADDR_BITS  = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] frame_addr,
    input  logic                 frame_start,
    input  logic                 next_pixel,
    output logic [5:0]           colour,
    output logic                 colour_valid,
    output logic                 underrun,
    output logic [ADDR_BITS-1:0] flash_addr,
    output logic                 flash_start,
    output logic                 flash_stop,
    output logic                 flash_continue,
    input  logic [15:0]          flash_data,
    input  logic                 flash_busy
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic         restart_r;
    logic         restart_nxt_s;
    logic         wait_first_r;
    logic [ADDR_BITS-1:0] addr_r;

    logic         capture_s;
    logic         is_end_s;
    logic         push_s;
    logic         pop_s;
    logic         starve_s;
    logic         can_continue_s;
    logic         fifo_flush_s;
    logic         fifo_full_s;
    logic         fifo_empty_s;
    logic [ENTRY_BITS-1:0] head_word_s;
    run_entry_t   head_s;

    logic                 flash_start_r;
    logic                 flash_start_nxt_s;
    logic                 flash_stop_r;
    logic                 flash_stop_nxt_s;
    logic [ADDR_BITS-1:0] flash_addr_r;
    logic [ADDR_BITS-1:0] flash_addr_nxt_s;
    logic                 flash_continue_s;

    logic [RUN_BITS-1:0]    cnt_r;
    logic [COLOUR_BITS-1:0] colour_r;
    logic                   valid_r;
    logic                   underrun_r;

    assign head_s       = to_entry(head_word_s);
    assign capture_s    = (state_r == ST_WAIT) && !wait_first_r && !flash_busy;
    assign is_end_s     = (flash_data[ENTRY_BITS-1:COLOUR_BITS] == END_MARKER);
    assign fifo_flush_s = frame_start || (state_r == ST_STOP);
    assign can_continue_s = !fifo_full_s || pop_s;

    rle_run_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush_s),
        .push      (push_s),
        .push_data (flash_data),
        .pop       (pop_s),
        .pop_data  (head_word_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Fetch FSM state, pending restart and captured frame address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_STOP;
            restart_r    <= 1'b0;
            wait_first_r <= 1'b1;
            addr_r       <= '0;
        end else begin
            state_r      <= state_nxt_s;
            restart_r    <= restart_nxt_s;
            // High during the first WAIT cycle, while the controller has not
            // yet had a chance to raise busy for the new request.
            wait_first_r <= (state_r != ST_WAIT);
            if (frame_start) begin
                addr_r <= frame_addr;
            end
        end
    end

    // Fetch FSM next-state logic; frame_start overrides everything.
    always_comb begin
        state_nxt_s   = state_r;
        restart_nxt_s = restart_r;
        if (frame_start) begin
            if ((state_r == ST_STOP) || (state_r == ST_DONE)) begin
                state_nxt_s   = ST_START;
                restart_nxt_s = 1'b0;
            end else begin
                // A read may be in flight: spend one cycle in STOP first.
                state_nxt_s   = ST_STOP;
                restart_nxt_s = 1'b1;
            end
        end else begin
            case (state_r)
                ST_STOP: begin
                    if (restart_r) begin
                        state_nxt_s   = ST_START;
                        restart_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
                ST_START: state_nxt_s = ST_WAIT;
                ST_WAIT: begin
                    if (capture_s) begin
                        state_nxt_s = is_end_s ? ST_DONE : ST_HOLD;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (can_continue_s) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_DONE: state_nxt_s = ST_DONE;
                default: begin
                    state_nxt_s   = ST_STOP;
                    restart_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM outputs. start/stop/addr are decoded from the next state and
    // registered so they line up with the state register. continue must be
    // seen by the controller before the first WAIT cycle, so it is decoded
    // directly from HOLD.
    always_comb begin
        flash_start_nxt_s = (state_nxt_s == ST_START);
        flash_stop_nxt_s  = (state_nxt_s == ST_STOP) || (state_nxt_s == ST_DONE);
        if (state_nxt_s == ST_START) begin
            flash_addr_nxt_s = frame_start ? frame_addr : addr_r;
        end else begin
            flash_addr_nxt_s = flash_addr_r;
        end
        flash_continue_s = (state_r == ST_HOLD) && can_continue_s && !frame_start;
        push_s           = capture_s && !is_end_s && !frame_start;
    end

    // Registered flash command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            flash_start_r <= 1'b0;
            flash_stop_r  <= 1'b1;
            flash_addr_r  <= '0;
        end else begin
            flash_start_r <= flash_start_nxt_s;
            flash_stop_r  <= flash_stop_nxt_s;
            flash_addr_r  <= flash_addr_nxt_s;
        end
    end

    // Output stage decisions: load a new run or report starvation.
    always_comb begin
        pop_s    = 1'b0;
        starve_s = 1'b0;
        if (frame_start) begin
            pop_s    = 1'b0;
            starve_s = 1'b0;
        end else if (!valid_r) begin
            pop_s = !fifo_empty_s;
        end else if (next_pixel && (cnt_r == 10'd1)) begin
            pop_s    = !fifo_empty_s;
            starve_s = fifo_empty_s;
        end else begin
            pop_s    = 1'b0;
            starve_s = 1'b0;
        end
    end

    // Run counter, colour register and sticky underrun flag.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            cnt_r      <= 10'd0;
            colour_r   <= 6'd0;
            valid_r    <= 1'b0;
            underrun_r <= 1'b0;
        end else if (pop_s) begin
            cnt_r    <= head_s.len;
            colour_r <= head_s.colour;
            valid_r  <= 1'b1;
        end else if (starve_s) begin
            cnt_r    <= 10'd0;
            colour_r <= 6'd0;
            valid_r  <= 1'b0;
            // Running dry after the end marker is simply end of frame.
            if (state_r != ST_DONE) begin
                underrun_r <= 1'b1;
            end
        end else if (valid_r && next_pixel) begin
            cnt_r <= cnt_r - 10'd1;
        end
    end

    assign colour         = colour_r;
    assign colour_valid   = valid_r;
    assign underrun       = underrun_r;
    assign flash_addr     = flash_addr_r;
    assign flash_start    = flash_start_r;
    assign flash_stop     = flash_stop_r;
    assign flash_continue = flash_continue_s;

endmodule

// File: tb/tb_rle_decoder.sv
// tb_rle_decoder -- directed bench for rle_decoder with a behavioural flash
// controller. Inputs are driven and outputs sampled on the falling edge.
module tb_rle_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_addr;
    logic        frame_start;
    logic        next_pixel;
    logic [5:0]  colour;
    logic        colour_valid;
    logic        underrun;
    logic [15:0] flash_addr;
    logic        flash_start;
    logic        flash_stop;
    logic        flash_continue;
    logic [15:0] flash_data;
    logic        flash_busy;

    int n_vec = 0;
    int n_err = 0;
    int busy_len = 2;
    int busy_cnt;
    logic [15:0] base_r;
    logic [15:0] idx_r;
    logic seen_old;
    int cnt_a;
    int cnt_b;
    int cnt_c;

    rle_decoder #(.ADDR_BITS(16), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_addr     (frame_addr),
        .frame_start    (frame_start),
        .next_pixel     (next_pixel),
        .colour         (colour),
        .colour_valid   (colour_valid),
        .underrun       (underrun),
        .flash_addr     (flash_addr),
        .flash_start    (flash_start),
        .flash_stop     (flash_stop),
        .flash_continue (flash_continue),
        .flash_data     (flash_data),
        .flash_busy     (flash_busy)
    );

    always #5 clk = ~clk;

    // Flash image: one short frame per base address.
    function automatic logic [15:0] word_at(input logic [15:0] a);
        case (a)
            16'h0100: word_at = 16'h0085;  // 2 x colour 5
            16'h0200: word_at = 16'h0081;  // 2 x colour 1
            16'h0201: word_at = 16'h00C2;  // 3 x colour 2
            16'h0300: word_at = 16'h0041;  // 1 x colour 1
            16'h0301: word_at = 16'h0042;
            16'h0302: word_at = 16'h0043;
            16'h1234: word_at = 16'h0083;  // 2 x colour 3
            default: begin
                if (a[15:8] == 8'h04 && a[7:0] < 8'd8) begin
                    word_at = {10'd1, 3'd0, a[2:0]};
                end else begin
                    word_at = 16'h0000;
                end
            end
        endcase
    endfunction

    // Behavioural flash controller: busy for busy_len cycles per request.
    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
            base_r   <= 16'h0000;
            idx_r    <= 16'h0000;
        end else if (flash_start) begin
            busy_cnt <= busy_len;
            base_r   <= flash_addr;
            idx_r    <= 16'h0000;
        end else if (flash_continue) begin
            busy_cnt <= busy_len;
            idx_r    <= idx_r + 16'd1;
        end else if (flash_stop) begin
            busy_cnt <= 0;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign flash_busy = (busy_cnt != 0);
    assign flash_data = word_at(base_r + idx_r);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [15:0] a);
        @(negedge clk);
        frame_addr  = a;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n;
        n = 0;
        while (!colour_valid && n < bound) begin
            @(negedge clk);
            if (colour_valid && colour == 6'd5) seen_old = 1'b1;
            n++;
        end
        check_eq(tag, 32'(colour_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] exp_col [5];
        exp_col[0] = 6'd1; exp_col[1] = 6'd1;
        exp_col[2] = 6'd2; exp_col[3] = 6'd2; exp_col[4] = 6'd2;
        rst = 1'b1; frame_addr = 16'h0000; frame_start = 1'b0; next_pixel = 1'b0;
        seen_old = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_colour",   32'(colour), 32'd0);
        check_eq("rst_valid",    32'(colour_valid), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_stop",     32'(flash_stop), 32'd1);
        check_eq("rst_start",    32'(flash_start), 32'd0);
        check_eq("rst_cont",     32'(flash_continue), 32'd0);
        check_eq("rst_addr",     32'(flash_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_stop", 32'(flash_stop), 32'd1);

        // Basic frame: let prefetch reach DONE, then consume continuously.
        busy_len = 2;
        start_frame(16'h0200);
        wait_valid("f1_first_valid", 50);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("f1_colour%0d", i), 32'(colour), 32'(exp_col[i]));
            check_eq($sformatf("f1_valid%0d", i), 32'(colour_valid), 32'd1);
            next_pixel = 1'b1;
            @(negedge clk);
        end
        check_eq("f1_end_valid",    32'(colour_valid), 32'd0);
        check_eq("f1_end_colour",   32'(colour), 32'd0);
        check_eq("f1_end_underrun", 32'(underrun), 32'd0);
        check_eq("f1_end_stop",     32'(flash_stop), 32'd1);
        next_pixel = 1'b0;

        // Slow flash, 1-pixel runs, continuous consumption: starvation.
        busy_len = 20;
        next_pixel = 1'b1;
        start_frame(16'h0300);
        wait_valid("f2_first_valid", 100);
        check_eq("f2_colour",   32'(colour), 32'd1);
        check_eq("f2_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        check_eq("f2_starve_valid",    32'(colour_valid), 32'd0);
        check_eq("f2_starve_colour",   32'(colour), 32'd0);
        check_eq("f2_starve_underrun", 32'(underrun), 32'd1);
        wait_valid("f2_second_valid", 100);
        check_eq("f2_second_colour", 32'(colour), 32'd2);
        check_eq("f2_sticky",        32'(underrun), 32'd1);
        next_pixel = 1'b0;
        start_frame(16'h0200);
        check_eq("f2_cleared", 32'(underrun), 32'd0);

        // Back-pressure: FIFO full, consumer idle.
        busy_len = 2;
        start_frame(16'h0400);
        repeat (40) @(negedge clk);
        cnt_a = 0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (flash_continue) cnt_a++;
        end
        check_eq("f3_no_continue", 32'(cnt_a), 32'd0);
        @(negedge clk);
        next_pixel = 1'b1;
        #1;
        check_eq("f3_continue_on_pop", 32'(flash_continue), 32'd1);
        cnt_a = flash_continue ? 1 : 0;
        @(negedge clk);
        next_pixel = 1'b0;
        #1;
        if (flash_continue) cnt_a++;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (flash_continue) cnt_a++;
        end
        check_eq("f3_one_continue", 32'(cnt_a), 32'd1);

        // Restart while a read is in flight.
        busy_len = 20;
        start_frame(16'h0100);
        repeat (3) @(negedge clk);
        frame_addr  = 16'h1234;
        frame_start = 1'b1;
        seen_old    = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        check_eq("f4_stop_pulse",  32'(flash_stop), 32'd1);
        check_eq("f4_no_start",    32'(flash_start), 32'd0);
        @(negedge clk);
        check_eq("f4_start",       32'(flash_start), 32'd1);
        check_eq("f4_addr",        32'(flash_addr), 32'h1234);
        check_eq("f4_stop_low",    32'(flash_stop), 32'd0);
        wait_valid("f4_valid", 100);
        check_eq("f4_colour",      32'(colour), 32'd3);
        check_eq("f4_old_not_shown", 32'(seen_old), 32'd0);

        // One-cycle reset in the middle of a run.
        busy_len = 2;
        start_frame(16'h0100);
        wait_valid("f5_valid", 50);
        check_eq("f5_colour", 32'(colour), 32'd5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("f5_rst_colour",   32'(colour), 32'd0);
        check_eq("f5_rst_valid",    32'(colour_valid), 32'd0);
        check_eq("f5_rst_underrun", 32'(underrun), 32'd0);
        check_eq("f5_rst_stop",     32'(flash_stop), 32'd1);
        check_eq("f5_rst_start",    32'(flash_start), 32'd0);
        check_eq("f5_rst_cont",     32'(flash_continue), 32'd0);
        check_eq("f5_rst_addr",     32'(flash_addr), 32'd0);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        repeat (20) begin
            @(negedge clk);
            if (flash_start) cnt_a++;
            if (!flash_stop) cnt_b++;
            if (colour_valid) cnt_c++;
        end
        check_eq("f5_stay_no_start", 32'(cnt_a), 32'd0);
        check_eq("f5_stay_stop",     32'(cnt_b), 32'd0);
        check_eq("f5_stay_invalid",  32'(cnt_c), 32'd0);
        start_frame(16'h0200);
        wait_valid("f5_recover_valid", 50);
        check_eq("f5_recover_colour", 32'(colour), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
